// File: rtl/pipe_trace_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_trace_buffer_pkg : shared capture-state encoding and helpers      |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package pipe_trace_buffer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ARMED     = 2'd1,
      ST_TRIGGERED = 2'd2,
      ST_DONE      = 2'd3
   } trace_state_t;

   // Width of a select field over n items; a single item still needs one bit.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_trace_buffer_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_ram : DEPTH x WIDTH sample store, one write port and one        |
// | registered read port (read register clears on reset).  Rev 1.0         |
// +----------------------------------------------------------------------+
module trace_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 128,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage is deliberately not reset so captured traces survive a reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipe_trace_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_trace_buffer : armed/triggered ring capture of pipeline words    |
// | with pre/post-trigger window and logical read-back.  Rev 1.0           |
// +----------------------------------------------------------------------+
module pipe_trace_buffer
   import pipe_trace_buffer_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int CHANNELS = 4,
   parameter int DEPTH    = 16,
   parameter int POST     = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               arm,
   input  logic                               trig_in,
   input  logic                               sample_valid,
   input  logic [CHANNELS*DATA_W-1:0]         sample_data,
   input  logic [$clog2(DEPTH)-1:0]           rd_addr,
   input  logic [sel_width(CHANNELS)-1:0]     rd_chan,
   output logic [DATA_W-1:0]                  rd_data,
   output logic [1:0]                         state,
   output logic [$clog2(DEPTH):0]             fill,
   output logic [$clog2(DEPTH)-1:0]           trig_idx
);

   localparam int AW     = $clog2(DEPTH);
   localparam int CW     = sel_width(CHANNELS);
   localparam int WORD_W = CHANNELS * DATA_W;

   trace_state_t       cur_state, nxt_state;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      trig_addr;
   logic [AW-1:0]      post_cnt;
   logic [AW:0]        fill_cnt;
   logic               full;
   logic               wr_en;
   logic               start;
   logic               trig_hit;
   logic [AW-1:0]      trig_phys;
   logic [AW-1:0]      base;
   logic [AW-1:0]      rd_phys;
   logic [WORD_W-1:0]  word_q;
   logic [CW-1:0]      rd_chan_q;

   assign full = (fill_cnt == (AW+1)'(DEPTH));
   // Once the ring has wrapped, the oldest sample sits at the write pointer.
   assign base = full ? wr_ptr : '0;

   always_comb begin
      if (sample_valid) begin
         trig_phys = wr_ptr;
      end else if (fill_cnt != '0) begin
         trig_phys = wr_ptr - AW'(1);
      end else begin
         trig_phys = '0;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      wr_en     = 1'b0;
      start     = 1'b0;
      trig_hit  = 1'b0;
      case (cur_state)
         ST_IDLE, ST_DONE: begin
            if (arm) begin
               nxt_state = ST_ARMED;
               start     = 1'b1;
            end
         end
         ST_ARMED: begin
            wr_en = sample_valid;
            if (trig_in) begin
               trig_hit  = 1'b1;
               nxt_state = (POST == 0 && sample_valid) ? ST_DONE : ST_TRIGGERED;
            end
         end
         ST_TRIGGERED: begin
            if (POST == 0) begin
               nxt_state = ST_DONE;
            end else begin
               wr_en = sample_valid;
               if (sample_valid && post_cnt == AW'(POST - 1)) begin
                  nxt_state = ST_DONE;
               end
            end
         end
         default: nxt_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state <= ST_IDLE;
         wr_ptr    <= '0;
         fill_cnt  <= '0;
         post_cnt  <= '0;
         trig_addr <= '0;
      end else begin
         cur_state <= nxt_state;
         if (start) begin
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            post_cnt  <= '0;
            trig_addr <= '0;
         end
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (!full) begin
               fill_cnt <= fill_cnt + (AW+1)'(1);
            end
         end
         if (trig_hit) begin
            trig_addr <= trig_phys;
         end
         if (cur_state == ST_TRIGGERED && wr_en) begin
            post_cnt <= post_cnt + AW'(1);
         end
      end
   end

   assign rd_phys = rd_addr + base;

   trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (WORD_W)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (sample_data),
      .raddr (rd_phys),
      .rdata (word_q)
   );

   // Channel select is delayed to line up with the registered RAM word.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_chan_q <= '0;
      end else begin
         rd_chan_q <= rd_chan;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (rd_chan_q == CW'(k)) begin
            rd_data = word_q[k*DATA_W +: DATA_W];
         end
      end
   end

   assign state    = cur_state;
   assign fill     = fill_cnt;
   assign trig_idx = trig_addr - base;

endmodule
`default_nettype wire

// File: doc/pipe_trace_buffer.md
PIPE_TRACE_BUFFER -- requirements
Module: pipe_trace_buffer

Interface
REQ-001 Parameter DATA_W, default 32, width of one traced pipeline word (e.g. instruction_EX, ALU_result_MEM).
REQ-002 Parameter CHANNELS, default 4, number of traced words captured per sample.
REQ-003 Parameter DEPTH, default 16, samples stored; power of two, >= 4.
REQ-004 Parameter POST, default 8, samples captured after the trigger sample; 0 <= POST <= DEPTH-1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 arm  input  1  one-cycle pulse; starts a capture.
REQ-008 trig_in  input  1  trigger condition, e.g. BranchTaken or IF_Flush.
REQ-009 sample_valid  input  1  sample_data is valid this cycle.
REQ-010 sample_data  input  CHANNELS*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
REQ-011 rd_addr  input  log2(DEPTH)  logical read index; 0 = oldest stored sample.
REQ-012 rd_chan  input  log2(CHANNELS), min 1  channel select.
REQ-013 rd_data  output  DATA_W  registered read data.
REQ-014 state  output  2  IDLE=0, ARMED=1, TRIGGERED=2, DONE=3.
REQ-015 fill  output  log2(DEPTH)+1  stored sample count, saturates at DEPTH.
REQ-016 trig_idx  output  log2(DEPTH)  logical index of the trigger sample, valid in DONE.

Function
REQ-017 IDLE: no writes; arm moves to ARMED next cycle and clears fill and the write pointer to 0.
REQ-018 ARMED: each cycle with sample_valid=1 writes all channels at the write pointer; pointer increments mod DEPTH; fill increments, saturating at DEPTH.
REQ-019 ARMED with trig_in=1: the trigger cycle's sample is written if valid; the trigger physical address is recorded (pointer value at that cycle, or pointer-1 mod DEPTH if sample_valid=0 and fill>0, or 0 if fill=0); state moves to TRIGGERED, or directly to DONE when POST=0 and sample_valid=1.
REQ-020 trig_in and arm in the same IDLE cycle: trigger ignored. trig_in in IDLE, TRIGGERED or DONE: ignored.
REQ-021 TRIGGERED: writes continue as in ARMED; post counter counts valid samples after the trigger sample; on the POST-th valid sample, that sample is written and state moves to DONE the next cycle.
REQ-022 DONE: no writes; buffer, fill and pointers are frozen; arm restarts as in REQ-017.
REQ-023 arm while in ARMED or TRIGGERED: ignored.
REQ-024 Logical-to-physical read mapping: physical = (rd_addr + (fill==DEPTH ? wr_ptr : 0)) mod DEPTH.
REQ-025 trig_idx = (trigger physical address - (fill==DEPTH ? wr_ptr : 0)) mod DEPTH.
REQ-026 rd_data has 1-cycle latency from rd_addr/rd_chan and is readable in any state.
REQ-027 Read of an address at or beyond fill returns stale contents; no error flag.

Reset
REQ-028 reset: state=IDLE, fill=0, wr_ptr=0, post counter=0, trig_idx=0, rd_data=0; storage contents are not cleared.
REQ-029 reset overrides arm, trig_in and sample_valid in the same cycle; reset mid-capture aborts it.

Structure
REQ-030 A shared package holds the state encoding (trace_state_t) and the channel-slice width helper.
REQ-031 Storage is one sub-module, trace_ram: DEPTH x (CHANNELS*DATA_W), 1 write port, 1 registered read port; the channel mux follows the RAM read.

Verification
Bench parameters for all scenarios: DEPTH=8, CHANNELS=2, POST=3.
REQ-032 Wrap-around: arm, 12 valid samples 0..11 with no trigger -> fill=8, state=ARMED.
REQ-033 Wrap-around trigger: after REQ-032, trig_in with sample 12, then samples 13,14,15 -> state=DONE; rd_addr 0..7 read 8..15; trig_idx=4.
REQ-034 Early trigger: arm, trig_in on the first valid sample (value 0x100), then 3 valid samples -> fill=4, trig_idx=0, rd_addr 0 reads 0x100.
REQ-035 Gapped valid: arm, trigger, then sample_valid toggled 1,0,1,0,1 -> DONE only after the third valid post-trigger sample; invalid cycles write nothing.
REQ-036 Reset mid-capture: reset asserted in TRIGGERED -> next cycle state=0, fill=0, rd_data=0; later arm restarts cleanly.
REQ-037 Ignored events: trig_in with arm in the same cycle, and arm in ARMED -> no state change, capture continues.
